// File: rtl/hack_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg -- shared definitions for the Hack CPU core.
//   * word / address widths
//   * instruction field bit positions (type, a, comp, dest, jump)
//   * control FSM state encoding
// ---------------------------------------------------------------------------
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  // Instruction type: 0 = A-instruction, 1 = C-instruction
  localparam int unsigned IR_TYPE    = 15;
  // C-instruction: ALU y operand select (0 = A, 1 = M)
  localparam int unsigned IR_A       = 12;
  // C-instruction comp field, ordered zx,nx,zy,ny,f,no from MSB to LSB
  localparam int unsigned IR_ZX      = 11;
  localparam int unsigned IR_NX      = 10;
  localparam int unsigned IR_ZY      = 9;
  localparam int unsigned IR_NY      = 8;
  localparam int unsigned IR_F       = 7;
  localparam int unsigned IR_NO      = 6;
  // C-instruction destination field
  localparam int unsigned IR_DEST_A  = 5;
  localparam int unsigned IR_DEST_D  = 4;
  localparam int unsigned IR_DEST_M  = 3;
  // C-instruction jump field
  localparam int unsigned IR_JLT     = 2;
  localparam int unsigned IR_JEQ     = 1;
  localparam int unsigned IR_JGT     = 0;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- Hack ALU (purely combinational).
//   x, y      : 16-bit operands
//   zx, nx    : zero / negate x
//   zy, ny    : zero / negate y
//   f         : 1 = x + y, 0 = x & y
//   no        : negate result
//   out       : result
//   zr, ng    : result is zero / result is negative (two's complement)
// ---------------------------------------------------------------------------
module alu
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  word_t x_pre;
  word_t y_pre;
  word_t res;

  always_comb begin
    x_pre = zx ? '0 : x;
    if (nx) begin
      x_pre = ~x_pre;
    end
    y_pre = zy ? '0 : y;
    if (ny) begin
      y_pre = ~y_pre;
    end
    res = f ? (x_pre + y_pre) : (x_pre & y_pre);
    if (no) begin
      res = ~res;
    end
  end

  assign out = res;
  assign zr  = (res == '0);
  assign ng  = res[WORD_W-1];

endmodule

// File: rtl/hack_cpu_core.sv
// ---------------------------------------------------------------------------
// hack_cpu_core -- multi-cycle Hack CPU (FETCH -> EXEC, 2 cycles/instr min).
//
// Ports
//   clk         : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   imem_req    : instruction fetch request (high in FETCH)
//   imem_addr   : fetch address (= pc)
//   imem_rdata  : instruction word
//   imem_valid  : imem_rdata valid this cycle (only looked at in FETCH)
//   dmem_addr   : data address (= A[14:0])
//   dmem_rdata  : M = RAM[A], combinational read
//   dmem_wdata  : write data (ALU output)
//   dmem_we     : data write strobe (EXEC of a C-instruction with dest M)
//   pc          : program counter
//   halted      : halt indicator
//
// Optional feature: HACK_CPU_HALT_DETECT_EN
//   When defined, a taken jump whose target equals the current pc parks the
//   core in HALT (no fetch, no writes) until reset. When undefined, halted
//   is tied low and such self-jumps simply loop.
// ---------------------------------------------------------------------------
module hack_cpu_core
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  cpu_state_t state, state_d;
  addr_t      pc_d;
  word_t      a_q, a_d;
  word_t      d_q, d_d;
  word_t      ir_q, ir_d;

  word_t      alu_y;
  word_t      alu_out;
  logic       alu_zr;
  logic       alu_ng;
  logic       jump_taken;
  addr_t      pc_inc;

  // ALU: x is always D, y selects between A and M on the a-bit.
  assign alu_y = ir_q[IR_A] ? dmem_rdata : a_q;

  alu u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (ir_q[IR_ZX]),
    .nx  (ir_q[IR_NX]),
    .zy  (ir_q[IR_ZY]),
    .ny  (ir_q[IR_NY]),
    .f   (ir_q[IR_F]),
    .no  (ir_q[IR_NO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump_taken = (ir_q[IR_JLT] & alu_ng)
                    | (ir_q[IR_JEQ] & alu_zr)
                    | (ir_q[IR_JGT] & ~alu_ng & ~alu_zr);

  // 15-bit increment wraps 32767 -> 0 naturally.
  assign pc_inc = pc + 15'd1;

  assign imem_addr  = pc;
  assign dmem_addr  = a_q[ADDR_W-1:0];
  assign dmem_wdata = alu_out;

  // -------------------------------------------------------------------------
  // State register and architectural registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= '0;
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      a_q   <= a_d;
      d_q   <= d_d;
      ir_q  <= ir_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / next-register / output logic
  // All EXEC updates are computed from the pre-edge A, D and pc, so the
  // M write address and jump target are the old A even when A is a dest.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    dmem_we  = 1'b0;

    unique case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        if (!ir_q[IR_TYPE]) begin
          a_d  = {1'b0, ir_q[ADDR_W-1:0]};
          pc_d = pc_inc;
        end else begin
          if (ir_q[IR_DEST_A]) begin
            a_d = alu_out;
          end
          if (ir_q[IR_DEST_D]) begin
            d_d = alu_out;
          end
          dmem_we = ir_q[IR_DEST_M];
          pc_d    = jump_taken ? a_q[ADDR_W-1:0] : pc_inc;
`ifdef HACK_CPU_HALT_DETECT_EN
          // A taken jump back onto itself can never make progress: park.
          if (jump_taken && (a_q[ADDR_W-1:0] == pc)) begin
            state_d = ST_HALT;
          end
`endif
        end
      end

      ST_HALT: begin
        // Everything holds; only reset leaves this state.
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // No memory write may escape while reset is asserted.
    if (!rst_n) begin
      dmem_we = 1'b0;
    end
  end

`ifdef HACK_CPU_HALT_DETECT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/hack_cpu_core.md
HACK_CPU_CORE -- requirements
Module: hack_cpu_core

Interface
REQ-001 The block SHALL have the following ports, in order:
  - clk  in  1  sole clock; all state changes on rising edge.
  - rst_n  in  1  reset, synchronous, active-low.
  - imem_req  out  1  instruction fetch request.
  - imem_addr  out  15  fetch address, equal to pc.
  - imem_rdata  in  16  instruction word.
  - imem_valid  in  1  imem_rdata valid this cycle.
  - dmem_addr  out  15  data address, equal to A[14:0].
  - dmem_rdata  in  16  M = RAM[A], combinational read.
  - dmem_wdata  out  16  write data, the ALU output.
  - dmem_we  out  1  data write strobe.
  - pc  out  15  program counter.
  - halted  out  1  halt indicator.
REQ-002 Reset is synchronous and active-low on rst_n, clocked by clk, the single clock.

Function
REQ-003 The FSM SHALL have states FETCH, EXEC and HALT.
  - FETCH: imem_req=1.
  - imem_valid=1: the IR SHALL latch imem_rdata and the FSM SHALL go to EXEC.
  - imem_valid=0: all state SHALL hold.
REQ-004 imem_valid SHALL be ignored outside FETCH.
REQ-005 EXEC SHALL last exactly one cycle, then return to FETCH; minimum throughput is 2 cycles per instruction.
REQ-006 A-instruction (IR[15]=0): A SHALL load {1'b0, IR[14:0]}; D and M SHALL be unchanged; pc SHALL be pc+1.
REQ-007 C-instruction (IR[15]=1) decode:
  - IR[14:13] ignored.
  - ALU y = IR[12] ? dmem_rdata : A; ALU x = D.
  - IR[11:6] = zx,nx,zy,ny,f,no.
  - IR[5:3] = dest A,D,M.
  - IR[2:0] = jump lt,eq,gt.
REQ-008 dmem_we SHALL be 1 only in EXEC of a C-instruction with IR[3]=1 and rst_n=1.
REQ-009 All EXEC updates SHALL use pre-edge values:
  - M write address SHALL be the old A, even when A is also a destination.
  - Jump target SHALL be the old A[14:0].
REQ-010 The jump SHALL be taken when (lt & ng) | (eq & zr) | (gt & ~ng & ~zr); taken: pc <= A[14:0]; not taken: pc <= pc+1.
REQ-011 pc increment SHALL wrap 32767 -> 0 silently.
REQ-012 dest A and dest D SHALL both update when both are selected.

Reset
REQ-013 With rst_n=0 at a clock edge, the block SHALL reset to:
  - pc=0, A=0, D=0, IR=0.
  - state=FETCH, halted=0.
REQ-014 While rst_n=0, dmem_we SHALL be 0.
REQ-015 Reset during EXEC SHALL abort the instruction; no register or memory update SHALL occur.

Configuration
REQ-016 The feature macro SHALL be HACK_CPU_HALT_DETECT_EN.
REQ-017 With HACK_CPU_HALT_DETECT_EN defined, a taken jump in EXEC with old A[14:0]==pc SHALL:
  - enter HALT instead of FETCH;
  - keep pc unchanged.
REQ-018 HALT state behaviour:
  - imem_req=0, dmem_we=0, halted=1.
  - HALT SHALL exit only by reset.
REQ-019 Without HACK_CPU_HALT_DETECT_EN:
  - the halted port SHALL remain, tied to 0;
  - the HALT state SHALL never be entered;
  - self-jumps SHALL loop normally.

Structure
REQ-020 Package hack_pkg SHALL hold:
  - the state enum;
  - instruction bit-index constants (type, a, comp, dest, jump fields);
  - the word width 16 and address width 15.
REQ-021 The existing alu module SHALL be instantiated once as the only sub-module; the core SHALL add no other arithmetic beyond pc+1.

Verification
REQ-022 Data path: program @2, D=A (EC10), @3, D=D+A (E090), @0, M=D (E308) -> dmem_we=1 for one cycle with dmem_addr=0 and dmem_wdata=5.
REQ-023 Unconditional jump: @10, 0;JMP (EA87) -> next imem_addr=10.
  - @10 D=A then D;JLT (E304) with D=10 -> not taken, pc increments.
REQ-024 Fetch stall: hold imem_valid=0 for 3 cycles in FETCH -> imem_req=1 throughout, pc and A/D unchanged; instruction executes on the first valid cycle.
REQ-025 Wrap: jump to 32767, execute an A-instruction there -> next imem_addr=0.
REQ-026 Reset mid-EXEC of M=D -> dmem_we=0; after release, pc=0, A=0, D=0, FSM in FETCH.
  - With HACK_CPU_HALT_DETECT_EN: @5 at 4, 0;JMP at 5 -> halted=1, imem_req=0, pc=5 held.
